i2c_master_ctrl: RTL

Single-byte I2C master sequencer clocked from ref_clk. It generates SCL internally from a quarter-period tick counter, so no separate divided clock is used. It runs one transaction per accepted command: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP. It then returns a one-cycle response. It sits between the register/command logic and the open-drain SCL/SDA pads.

---
 rtl/i2c_master_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, {addr,rw}, ACK, one data byte, ACK/NACK, STOP.
// SCL is derived from a quarter-bit tick counter; SDA is an open-drain pull-low request.
module i2c_master_ctrl #(
   parameter int QTR_DIV = 250
) (
   input  logic       ref_clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       busy,
   output logic       scl_o,
   output logic       sda_drive_low,
   input  logic       sda_i,
   output logic [2:0] dbg_state
);

   // Handshake: a command is taken on a rising edge where cmd_valid and cmd_ready are
   // both high; the requester holds cmd_* stable until then. rsp_valid is a single-cycle
   // pulse with no back-pressure, and rsp_rdata/rsp_nack hold until the next accept.

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      ADDR     = 3'd2,
      ADDR_ACK = 3'd3,
      DATA     = 3'd4,
      DATA_ACK = 3'd5,
      STOP     = 3'd6
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [9:0] tick_cnt;
   logic [1:0] phase;
   logic [2:0] bit_cnt;
   logic [2:0] bit_idx;
   logic [7:0] addr_byte;
   logic [7:0] wdata_q;
   logic [7:0] rdata_q;
   logic       nack_q;
   logic       tick;
   logic       sample;
   logic       phase_end;
   logic       rw_q;

   assign tick      = (tick_cnt == 10'(QTR_DIV - 1));
   assign sample    = tick && (phase == 2'd2);
   assign phase_end = tick && (phase == 2'd3);
   assign bit_idx   = 3'd7 - bit_cnt;
   assign rw_q      = addr_byte[0];

   assign busy      = (state != IDLE);
   assign rsp_rdata = rdata_q;
   assign rsp_nack  = nack_q;
   assign dbg_state = state;

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         phase     <= '0;
         bit_cnt   <= '0;
         addr_byte <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         nack_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            tick_cnt <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            if (cmd_valid) begin
               addr_byte <= {cmd_addr, cmd_rw};
               wdata_q   <= cmd_wdata;
               rdata_q   <= '0;
               nack_q    <= 1'b0;
            end
         end else begin
            tick_cnt <= tick ? 10'd0 : tick_cnt + 10'd1;
            if (tick) phase <= phase + 2'd1;
            // bit_cnt wraps 7->0 on its own, so it is already zero for the next byte
            if (phase_end && (state == ADDR || state == DATA)) bit_cnt <= bit_cnt + 3'd1;
            if (sample) begin
               case (state)
                  ADDR_ACK: nack_q <= sda_i;
                  DATA:     if (rw_q) rdata_q <= {rdata_q[6:0], sda_i};
                  DATA_ACK: if (!rw_q && sda_i) nack_q <= 1'b1;
                  default:  ;
               endcase
            end
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      cmd_ready     = 1'b0;
      rsp_valid     = 1'b0;
      scl_o         = 1'b1;
      sda_drive_low = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = !reset;
            if (cmd_valid && !reset) state_nxt = START;
         end
         START: begin
            sda_drive_low = phase[1];
            if (phase_end) state_nxt = ADDR;
         end
         ADDR: begin
            scl_o         = phase[1];
            sda_drive_low = !addr_byte[bit_idx];
            if (phase_end && bit_cnt == 3'd7) state_nxt = ADDR_ACK;
         end
         ADDR_ACK: begin
            scl_o = phase[1];
            // nack_q was captured at the end of phase 2, so it is valid here
            if (phase_end) state_nxt = nack_q ? STOP : DATA;
         end
         DATA: begin
            scl_o         = phase[1];
            sda_drive_low = !rw_q && !wdata_q[bit_idx];
            if (phase_end && bit_cnt == 3'd7) state_nxt = DATA_ACK;
         end
         DATA_ACK: begin
            scl_o = phase[1];
            if (phase_end) state_nxt = STOP;
         end
         STOP: begin
            scl_o         = (phase != 2'd0);
            sda_drive_low = (phase != 2'd3);
            if (phase_end) begin
               rsp_valid = !reset;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
